pipeline_controller: RTL and testbench



---
 rtl/pipeline_controller_pkg.sv | 83 ++++++++
 rtl/pipeline_controller_if.sv | 30 +++
 rtl/pipeline_controller_cond_unit.sv | 30 +++
 rtl/pipeline_controller.sv | 138 +++++++++++++
 tb/tb_pipeline_controller.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/pipeline_controller_pkg.sv
// Shared encodings for the pipelined ARM-subset control unit: opcodes,
// data-processing commands, ALU/flag-write selects, condition codes and
// the condition evaluator used in Execute.
package pipeline_controller_pkg;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;

  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_ORR = 4'b1100;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_AND = 2'b10,
    ALU_ORR = 2'b11
  } alu_ctrl_e;

  typedef enum logic [1:0] {
    FLAGW_NONE = 2'b00,
    FLAGW_NZ   = 2'b10,
    FLAGW_ALL  = 2'b11
  } flagw_e;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;
  localparam logic [3:0] COND_NV = 4'b1111;

  // Control fields carried from Decode into Execute.
  typedef struct packed {
    logic       pcsrc;
    logic       regwrite;
    logic       memwrite;
    logic       memtoreg;
    logic       alusrc;
    logic [1:0] alucontrol;
    logic [1:0] flagw;
    logic       branch;
    logic [3:0] cond;
  } ctrl_de_t;

  // Evaluates a condition field against flags ordered {N,Z,C,V}.
  function automatic logic cond_holds(input logic [3:0] cond, input logic [3:0] flags);
    logic n, z, c, v;
    {n, z, c, v} = flags;
    case (cond)
      COND_EQ: return z;
      COND_NE: return !z;
      COND_CS: return c;
      COND_CC: return !c;
      COND_MI: return n;
      COND_PL: return !n;
      COND_VS: return v;
      COND_VC: return !v;
      COND_HI: return c && !z;
      COND_LS: return !c || z;
      COND_GE: return n == v;
      COND_LT: return n != v;
      COND_GT: return !z && (n == v);
      COND_LE: return z || (n != v);
      COND_AL: return 1'b1;
      COND_NV: return 1'b0;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/pipeline_controller_if.sv
// Datapath <-> control-unit signal bundle. The datapath side is the master
// (supplies instruction bits, ALU flags and flush), the controller is the slave.
interface pipeline_controller_if;
  logic [19:0] InstrD;
  logic [3:0]  ALUFlags;
  logic        FlushE;
  logic [1:0]  RegSrcD;
  logic [1:0]  ImmSrcD;
  logic        ALUSrcE;
  logic [1:0]  ALUControlE;
  logic        MemWriteM;
  logic        MemtoRegW;
  logic        RegWriteW;
  logic        PCSrcW;
  logic        RegWriteM;
  logic        MemtoRegE;
  logic        PCWrPendingF;

  modport master (
    output InstrD, ALUFlags, FlushE,
    input  RegSrcD, ImmSrcD, ALUSrcE, ALUControlE, MemWriteM, MemtoRegW,
           RegWriteW, PCSrcW, RegWriteM, MemtoRegE, PCWrPendingF
  );

  modport slave (
    input  InstrD, ALUFlags, FlushE,
    output RegSrcD, ImmSrcD, ALUSrcE, ALUControlE, MemWriteM, MemtoRegW,
           RegWriteW, PCSrcW, RegWriteM, MemtoRegE, PCWrPendingF
  );
endinterface

// File: rtl/pipeline_controller_cond_unit.sv
// NZCV flags register and Execute-stage condition check.
module cond_unit
  import pipeline_controller_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] CondE,
  input  logic [3:0] ALUFlags,
  input  logic [1:0] FlagWE,
  output logic       CondExE
);

  logic [3:0] flags_q, flags_d;

  assign CondExE = cond_holds(CondE, flags_q);

  // Next flags: NZ and CV halves load independently, only when the condition passed.
  always_comb begin
    flags_d = flags_q;
    if (FlagWE[1] && CondExE) flags_d[3:2] = ALUFlags[3:2];
    if (FlagWE[0] && CondExE) flags_d[1:0] = ALUFlags[1:0];
  end

  // Flags register.
  always_ff @(posedge clk) begin
    if (reset) flags_q <= '0;
    else       flags_q <= flags_d;
  end

endmodule

// File: rtl/pipeline_controller.sv
// Control unit for the five-stage ARM-subset pipeline: Decode-stage decoder,
// D->E->M->W control registers, and condition-gated write enables.
module pipeline_controller
  import pipeline_controller_pkg::*;
(
  input logic                 clk,
  input logic                 reset,
  pipeline_controller_if.slave ctl
);

  logic [1:0] op;
  logic [5:0] funct;
  logic [3:0] rd;
  logic [1:0] regsrc_d, immsrc_d;
  ctrl_de_t   ctrl_d, ctrl_e_q;
  logic       condex_e;
  logic       regwrite_m_q, memwrite_m_q, memtoreg_m_q, pcsrc_m_q;
  logic       regwrite_w_q, memtoreg_w_q, pcsrc_w_q;
  logic       unused_bits;

  assign op    = ctl.InstrD[15:14];
  assign funct = ctl.InstrD[13:8];
  assign rd    = ctl.InstrD[3:0];

  // Rn is consumed by the datapath; Branch is already folded into PCSrc.
  assign unused_bits = ^{ctl.InstrD[7:4], ctrl_e_q.branch};

  // Decode: instruction fields to control signals.
  always_comb begin
    regsrc_d = '0;
    immsrc_d = '0;
    ctrl_d   = '0;
    ctrl_d.cond = ctl.InstrD[19:16];
    case (op)
      OP_DP: begin
        ctrl_d.alusrc   = funct[5];
        ctrl_d.regwrite = 1'b1;
        case (funct[4:1])
          CMD_ADD: begin
            ctrl_d.alucontrol = ALU_ADD;
            ctrl_d.flagw      = funct[0] ? FLAGW_ALL : FLAGW_NONE;
          end
          CMD_SUB: begin
            ctrl_d.alucontrol = ALU_SUB;
            ctrl_d.flagw      = funct[0] ? FLAGW_ALL : FLAGW_NONE;
          end
          CMD_AND: begin
            ctrl_d.alucontrol = ALU_AND;
            ctrl_d.flagw      = funct[0] ? FLAGW_NZ : FLAGW_NONE;
          end
          CMD_ORR: begin
            ctrl_d.alucontrol = ALU_ORR;
            ctrl_d.flagw      = funct[0] ? FLAGW_NZ : FLAGW_NONE;
          end
          default: begin
            ctrl_d.regwrite   = 1'b0;
            ctrl_d.alucontrol = ALU_ADD;
          end
        endcase
      end
      OP_MEM: begin
        immsrc_d      = 2'b01;
        ctrl_d.alusrc = 1'b1;
        if (funct[0]) begin
          ctrl_d.memtoreg = 1'b1;
          ctrl_d.regwrite = 1'b1;
        end else begin
          regsrc_d        = 2'b10;
          ctrl_d.memwrite = 1'b1;
        end
      end
      OP_BR: begin
        regsrc_d      = 2'b01;
        immsrc_d      = 2'b10;
        ctrl_d.alusrc = 1'b1;
        ctrl_d.branch = 1'b1;
      end
      default: ;
    endcase
    ctrl_d.pcsrc = ((rd == 4'hF) && ctrl_d.regwrite) || ctrl_d.branch;
  end

  // D->E register; flush turns the entering instruction into a bubble.
  always_ff @(posedge clk) begin
    if (reset || ctl.FlushE) ctrl_e_q <= '0;
    else                     ctrl_e_q <= ctrl_d;
  end

  cond_unit u_cond (
    .clk      (clk),
    .reset    (reset),
    .CondE    (ctrl_e_q.cond),
    .ALUFlags (ctl.ALUFlags),
    .FlagWE   (ctrl_e_q.flagw),
    .CondExE  (condex_e)
  );

  // E->M register; architectural writes are squashed when the condition fails.
  always_ff @(posedge clk) begin
    if (reset) begin
      regwrite_m_q <= 1'b0;
      memwrite_m_q <= 1'b0;
      memtoreg_m_q <= 1'b0;
      pcsrc_m_q    <= 1'b0;
    end else begin
      regwrite_m_q <= ctrl_e_q.regwrite && condex_e;
      memwrite_m_q <= ctrl_e_q.memwrite && condex_e;
      memtoreg_m_q <= ctrl_e_q.memtoreg;
      pcsrc_m_q    <= ctrl_e_q.pcsrc && condex_e;
    end
  end

  // M->W register.
  always_ff @(posedge clk) begin
    if (reset) begin
      regwrite_w_q <= 1'b0;
      memtoreg_w_q <= 1'b0;
      pcsrc_w_q    <= 1'b0;
    end else begin
      regwrite_w_q <= regwrite_m_q;
      memtoreg_w_q <= memtoreg_m_q;
      pcsrc_w_q    <= pcsrc_m_q;
    end
  end

  assign ctl.RegSrcD      = regsrc_d;
  assign ctl.ImmSrcD      = immsrc_d;
  assign ctl.ALUSrcE      = ctrl_e_q.alusrc;
  assign ctl.ALUControlE  = ctrl_e_q.alucontrol;
  assign ctl.MemtoRegE    = ctrl_e_q.memtoreg;
  assign ctl.MemWriteM    = memwrite_m_q;
  assign ctl.RegWriteM    = regwrite_m_q;
  assign ctl.MemtoRegW    = memtoreg_w_q;
  assign ctl.RegWriteW    = regwrite_w_q;
  assign ctl.PCSrcW       = pcsrc_w_q;
  assign ctl.PCWrPendingF = ctrl_d.pcsrc || ctrl_e_q.pcsrc || pcsrc_m_q;

endmodule

// File: tb/tb_pipeline_controller.sv
// Directed bench for pipeline_controller with a FIFO scoreboard of expectations.
module tb_pipeline_controller;

  localparam logic [19:0] I_NOP    = 20'hEC000;
  localparam logic [19:0] I_ADDS   = 20'hE2921;
  localparam logic [19:0] I_ADD    = 20'hE2821;
  localparam logic [19:0] I_ADDSEQ = 20'h02921;
  localparam logic [19:0] I_SUBS   = 20'hE2521;
  localparam logic [19:0] I_ANDS   = 20'hE2121;
  localparam logic [19:0] I_BEQ    = 20'h0A000;
  localparam logic [19:0] I_BNE    = 20'h1A000;
  localparam logic [19:0] I_STR    = 20'hE5812;
  localparam logic [19:0] I_LDR    = 20'hE5912;

  logic clk = 1'b0;
  logic reset;

  pipeline_controller_if ifc ();

  pipeline_controller dut (
    .clk   (clk),
    .reset (reset),
    .ctl   (ifc)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      tag;
    logic [8:0] v;
  } exp_t;

  exp_t        sbq[$];
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  logic [8:0] regs_all, dec_o, e_o, m_o, w_o, pend_o, flags_o;
  assign regs_all = {ifc.ALUSrcE, ifc.ALUControlE, ifc.MemWriteM, ifc.MemtoRegW,
                     ifc.RegWriteW, ifc.PCSrcW, ifc.RegWriteM, ifc.MemtoRegE};
  assign dec_o    = {5'd0, ifc.RegSrcD, ifc.ImmSrcD};
  assign e_o      = {5'd0, ifc.ALUSrcE, ifc.ALUControlE, ifc.MemtoRegE};
  assign m_o      = {7'd0, ifc.RegWriteM, ifc.MemWriteM};
  assign w_o      = {6'd0, ifc.RegWriteW, ifc.MemtoRegW, ifc.PCSrcW};
  assign pend_o   = {8'd0, ifc.PCWrPendingF};
  assign flags_o  = {5'd0, dut.u_cond.flags_q};

  task automatic push(input string tag, input logic [8:0] v);
    exp_t e;
    e.tag = tag;
    e.v   = v;
    sbq.push_back(e);
  endtask

  task automatic pop_chk(input logic [8:0] obs);
    exp_t e;
    n_cmp++;
    if (sbq.size() == 0) begin
      n_bad++;
      $error("FAIL sb_underflow observed=%h expected=<none>", obs);
    end else begin
      e = sbq.pop_front();
      assert (obs === e.v) else begin
        n_bad++;
        $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.v);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset        = 1'b1;
    ifc.InstrD   = I_NOP;
    ifc.ALUFlags = 4'b0000;
    ifc.FlushE   = 1'b0;
    tick();
    tick();
    push("reset_regs", 9'h000);
    push("reset_flags", 9'h000);
    pop_chk(regs_all);
    pop_chk(flags_o);
    reset = 1'b0;

    // ADDS R1,R2,#5
    ifc.InstrD = I_ADDS;
    push("adds_dec", 9'h000);
    push("adds_e", 9'h008);
    push("adds_m", 9'h002);
    push("adds_flags", 9'h003);
    push("adds_w", 9'h004);
    #1 pop_chk(dec_o);
    tick(); ifc.InstrD = I_NOP; ifc.ALUFlags = 4'b0011; pop_chk(e_o);
    tick(); ifc.ALUFlags = 4'b0000; pop_chk(m_o); pop_chk(flags_o);
    tick(); pop_chk(w_o);

    // SUBS sets Z, then BEQ taken
    ifc.InstrD = I_SUBS;
    push("subs_flags", 9'h004);
    push("beq_pend_e", 9'h001);
    push("beq_w", 9'h001);
    tick(); ifc.InstrD = I_BEQ; ifc.ALUFlags = 4'b0100;
    tick(); ifc.InstrD = I_NOP; ifc.ALUFlags = 4'b0000; pop_chk(flags_o); pop_chk(pend_o);
    tick();
    tick(); pop_chk(w_o);

    // BNE with Z still set: not taken
    ifc.InstrD = I_BNE;
    push("bne_pend_d", 9'h001);
    push("bne_pend_m", 9'h000);
    push("bne_w", 9'h000);
    #1 pop_chk(pend_o);
    tick(); ifc.InstrD = I_NOP;
    tick(); pop_chk(pend_o);
    tick(); pop_chk(w_o);

    // STR
    ifc.InstrD = I_STR;
    push("str_dec", 9'h009);
    push("str_m", 9'h001);
    push("str_w", 9'h000);
    #1 pop_chk(dec_o);
    tick(); ifc.InstrD = I_NOP;
    tick(); pop_chk(m_o);
    tick(); pop_chk(w_o);

    // LDR
    ifc.InstrD = I_LDR;
    push("ldr_e", 9'h009);
    push("ldr_w", 9'h006);
    tick(); ifc.InstrD = I_NOP; pop_chk(e_o);
    tick();
    tick(); pop_chk(w_o);

    // SUBS clears Z, ADDSEQ fails, ANDS updates NZ only
    ifc.InstrD = I_SUBS;
    push("subs2_e", 9'h00A);
    push("subs2_flags", 9'h003);
    push("addseq_m", 9'h000);
    push("addseq_flags", 9'h003);
    push("ands_flags", 9'h00B);
    tick(); ifc.InstrD = I_ADDSEQ; ifc.ALUFlags = 4'b0011; pop_chk(e_o);
    tick(); ifc.InstrD = I_ANDS; ifc.ALUFlags = 4'b1100; pop_chk(flags_o);
    tick(); ifc.InstrD = I_NOP; ifc.ALUFlags = 4'b1000; pop_chk(m_o); pop_chk(flags_o);
    tick(); ifc.ALUFlags = 4'b0000; pop_chk(flags_o);

    // FlushE turns ADD into a bubble
    ifc.InstrD = I_ADD;
    ifc.FlushE = 1'b1;
    push("flush_e", 9'h000);
    push("flush_m", 9'h000);
    push("flush_w", 9'h000);
    tick(); ifc.FlushE = 1'b0; ifc.InstrD = I_NOP; pop_chk(e_o);
    tick(); pop_chk(m_o);
    tick(); pop_chk(w_o);

    // Reset with three instructions in flight
    ifc.InstrD = I_STR;
    tick(); ifc.InstrD = I_ADDS;
    tick(); ifc.InstrD = I_LDR; ifc.ALUFlags = 4'b0110;
    tick(); ifc.ALUFlags = 4'b0000;
    push("inflight_regs", 9'b1_00_0_0_0_0_1_1);
    push("inflight_flags", 9'h006);
    pop_chk(regs_all);
    pop_chk(flags_o);
    reset = 1'b1;
    ifc.InstrD = I_ADDS;
    ifc.ALUFlags = 4'b1111;
    tick();
    push("rst_regs", 9'h000);
    push("rst_flags", 9'h000);
    pop_chk(regs_all);
    pop_chk(flags_o);
    reset = 1'b0;
    ifc.InstrD = I_NOP;
    ifc.ALUFlags = 4'b0000;
    for (int i = 0; i < 3; i++) begin
      push("post_rst_regs", 9'h000);
      tick();
      pop_chk(regs_all);
    end

    n_cmp++;
    assert (sbq.size() == 0) else begin
      n_bad++;
      $error("FAIL sb_leftover observed=%0d expected=0", sbq.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
